alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 154 +++++++++++++++
 tb/tb_alu_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end that shares one combinational ALU
// between two requesters, one transaction in flight at a time.
//
//   state | meaning
//   IDLE  | waiting for a request; grant is combinational in this cycle
//   EXEC  | latched operands presented to the ALU; result captured at end
//   RESP  | response held on rsp_* until the consumer accepts it
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    input  logic [7:0]         req_sel,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [3:0]         alu_sel,
    input  logic [WIDTH-1:0]   alu_out,
    input  logic               alu_flag,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [WIDTH-1:0]   rsp_out,
    output logic               rsp_flag,
    output logic               rsp_err,
    output logic [15:0]        op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q;
    logic               ptr_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [3:0]         sel_q;
    logic               rsp_valid_q;
    logic               rsp_id_q;
    logic [WIDTH-1:0]   rsp_out_q;
    logic               rsp_flag_q;
    logic               rsp_err_q;
    logic [15:0]        op_cnt_q;
    logic [15:0]        op_cnt_nxt;
    logic               grant_vld;
    logic               grant_id;
    logic               sel_illegal;
    logic               handshake;

    // Grant selection: the pointer only matters when both requesters compete.
    // Gated by rst_n so req_ready stays low while reset is held.
    always_comb begin
        grant_vld = rst_n && (state_q == IDLE) && (req_valid != 2'b00);
        grant_id  = (req_valid == 2'b11) ? ptr_q : req_valid[1];
        req_ready = 2'b00;
        if (grant_vld) begin
            req_ready = grant_id ? 2'b10 : 2'b01;
        end
    end

    // Opcode legality and response handshake decode.
    always_comb begin
        sel_illegal = (sel_q == 4'd4) || (sel_q >= 4'd10);
        handshake   = rsp_valid_q && rsp_ready;
    end

    // Saturating completed-response counter, next value.
    always_comb begin
        op_cnt_nxt = op_cnt_q;
        if (handshake && (op_cnt_q != 16'hFFFF)) begin
            op_cnt_nxt = op_cnt_q + 16'd1;
        end
    end

    // Main sequencer: grant/latch, capture result, hold response until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_out_q   <= '0;
            rsp_flag_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        a_q      <= grant_id ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
                        b_q      <= grant_id ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
                        sel_q    <= grant_id ? req_sel[7:4] : req_sel[3:0];
                        rsp_id_q <= grant_id;
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    if (sel_illegal) begin
                        rsp_out_q  <= '0;
                        rsp_flag_q <= 1'b0;
                        rsp_err_q  <= 1'b1;
                    end else begin
                        rsp_out_q  <= alu_out;
                        rsp_flag_q <= alu_flag;
                        rsp_err_q  <= 1'b0;
                    end
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (handshake) begin
                        rsp_valid_q <= 1'b0;
                        ptr_q       <= ~rsp_id_q;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    // Response counter register; always reloads from the next-value logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt_q <= '0;
        end else begin
            op_cnt_q <= op_cnt_nxt;
        end
    end

    // Output mapping from registered state.
    always_comb begin
        alu_a     = a_q;
        alu_b     = b_q;
        alu_sel   = sel_q;
        rsp_valid = rsp_valid_q;
        rsp_id    = rsp_id_q;
        rsp_out   = rsp_out_q;
        rsp_flag  = rsp_flag_q;
        rsp_err   = rsp_err_q;
        op_count  = op_cnt_q;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: ALU model, grant/response monitors feeding queues,
// and one task per scenario popping the queues and comparing inline.
module tb_alu_arbiter;

    localparam int W = 32;

    typedef struct packed {
        logic         id;
        logic [W-1:0] out;
        logic         flag;
        logic         err;
    } rsp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [1:0]     req_valid = 2'b00;
    logic [1:0]     req_ready;
    logic [2*W-1:0] req_a = '0;
    logic [2*W-1:0] req_b = '0;
    logic [7:0]     req_sel = '0;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [3:0]     alu_sel;
    logic [W-1:0]   alu_out;
    logic           alu_flag;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic           rsp_id;
    logic [W-1:0]   rsp_out;
    logic           rsp_flag;
    logic           rsp_err;
    logic [15:0]    op_count;

    int   n_checks = 0;
    int   n_fail = 0;
    logic exp_ptr = 1'b0;
    logic [15:0] exp_cnt = 16'd0;

    rsp_t exp_q[$];
    rsp_t act_q[$];
    logic grant_q[$];

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_flag(alu_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_out(rsp_out), .rsp_flag(rsp_flag), .rsp_err(rsp_err),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [3:0] sel);
        logic [W-1:0] r;
        case (sel)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd5: r = a ^ b;
            4'd6: r = ~a;
            4'd7: r = a << 1;
            4'd8: r = a >> 1;
            4'd9: r = {{(W-1){1'b0}}, (a < b)};
            default: return {1'b1, 32'hDEAD_BEEF};
        endcase
        return {(r == '0), r};
    endfunction

    function automatic rsp_t model_rsp(input logic id, input logic [W-1:0] a,
                                       input logic [W-1:0] b, input logic [3:0] sel);
        rsp_t r;
        logic [W:0] f;
        r.id = id;
        if (sel == 4'd4 || sel >= 4'd10) begin
            r.out = '0; r.flag = 1'b0; r.err = 1'b1;
        end else begin
            f = alu_fn(a, b, sel);
            r.out = f[W-1:0]; r.flag = f[W]; r.err = 1'b0;
        end
        return r;
    endfunction

    always_comb begin
        {alu_flag, alu_out} = alu_fn(alu_a, alu_b, alu_sel);
    end

    // Monitors: record grants (with the model's expected response) and accepted responses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_ready != 2'b00) begin
                grant_q.push_back(req_ready[1]);
                if (req_ready[1])
                    exp_q.push_back(model_rsp(1'b1, req_a[W +: W], req_b[W +: W], req_sel[7:4]));
                else
                    exp_q.push_back(model_rsp(1'b0, req_a[0 +: W], req_b[0 +: W], req_sel[3:0]));
            end
            if (rsp_valid && rsp_ready)
                act_q.push_back({rsp_id, rsp_out, rsp_flag, rsp_err});
        end
    end

    task automatic set_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [3:0] sel);
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_sel[id*4 +: 4] = sel;
    endtask

    // Wait for a response handshake (bounded), then step past the accepting edge.
    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Single-requester transaction with rsp_ready held high.
    task automatic run_txn(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [3:0] sel, output bit ok);
        @(posedge clk); #1;
        set_req(id, a, b, sel);
        rsp_ready = 1'b1;
        req_valid = (id == 1) ? 2'b10 : 2'b01;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) break;
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_rsp(ok);
        if (ok && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        exp_ptr = (id == 1) ? 1'b0 : 1'b1;
    endtask

    task automatic test_reset();
        req_valid = 2'b11;
        set_req(0, 32'h1111, 32'h2222, 4'd0);
        set_req(1, 32'h3333, 32'h4444, 4'd1);
        repeat (3) @(negedge clk);
        n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_checks++; if ({rsp_id, rsp_out, rsp_flag, rsp_err} !== '0) begin n_fail++; $display("FAIL reset_rsp_fields got %h want 0", {rsp_id, rsp_out, rsp_flag, rsp_err}); end
        n_checks++; if (op_count !== 16'd0) begin n_fail++; $display("FAIL reset_op_count got %h want 0", op_count); end
        n_checks++; if ({alu_a, alu_b, alu_sel} !== '0) begin n_fail++; $display("FAIL reset_alu_regs got %h want 0", {alu_a, alu_b, alu_sel}); end
        req_valid = 2'b00;
        @(posedge clk); #3;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        rsp_t e, g;
        @(posedge clk); #1;
        set_req(0, 32'd5, 32'd3, 4'd0);
        rsp_ready = 1'b1;
        req_valid = 2'b01;
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_grant got %b want 01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 2'b00) begin n_fail++; $display("FAIL single_exec got valid=%b ready=%b want 0/00", rsp_valid, req_ready); end
        @(negedge clk);
        n_checks++; if ({rsp_valid, rsp_id, rsp_out, rsp_err} !== {1'b1, 1'b0, 32'd8, 1'b0}) begin n_fail++; $display("FAIL single_rsp got v=%b id=%b out=%0d err=%b want 1/0/8/0", rsp_valid, rsp_id, rsp_out, rsp_err); end
        @(posedge clk); #1;
        exp_cnt = 16'd1;
        exp_ptr = 1'b1;
        n_checks++; if (op_count !== 16'd1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_count got cnt=%0d valid=%b want 1/0", op_count, rsp_valid); end
        n_checks++;
        if (exp_q.size() != 1 || act_q.size() != 1 || grant_q.size() != 1) begin
            n_fail++; $display("FAIL single_queue got exp=%0d act=%0d want 1/1", exp_q.size(), act_q.size());
            exp_q.delete(); act_q.delete(); grant_q.delete();
        end else begin
            e = exp_q.pop_front(); g = act_q.pop_front(); void'(grant_q.pop_front());
            if (g !== e) begin n_fail++; $display("FAIL single_sb got %h want %h", g, e); end
        end
    endtask

    task automatic test_ops();
        rsp_t e, g;
        bit ok;
        logic [W-1:0] a, b;
        for (int s = 0; s < 16; s++) begin
            a = $urandom();
            b = (s == 9) ? a + 32'd1 : $urandom();
            if (s == 2) b = ~a;
            run_txn(s % 2, a, b, 4'(s), ok);
            n_checks++;
            if (!ok || act_q.size() != 1 || exp_q.size() != 1) begin
                n_fail++; $display("FAIL ops_sel%0d got ok=%0d act=%0d want response", s, ok, act_q.size());
                exp_q.delete(); act_q.delete(); grant_q.delete();
            end else begin
                e = exp_q.pop_front(); g = act_q.pop_front(); void'(grant_q.pop_front());
                if (g !== e || g.id !== 1'(s % 2)) begin n_fail++; $display("FAIL ops_sel%0d got %h want %h", s, g, e); end
            end
        end
        n_checks++; if (op_count !== exp_cnt) begin n_fail++; $display("FAIL ops_count got %0d want %0d", op_count, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        rsp_t e, g;
        logic gid;
        logic want;
        @(posedge clk); #1;
        set_req(0, 32'd100, 32'd7, 4'd1);
        set_req(1, 32'hF0, 32'h0F, 4'd3);
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        repeat (12) @(posedge clk);
        #1;
        req_valid = 2'b00;
        n_checks++;
        if (act_q.size() != 4 || exp_q.size() != 4 || grant_q.size() != 4) begin
            n_fail++; $display("FAIL b2b_count got rsp=%0d grants=%0d want 4/4", act_q.size(), grant_q.size());
            exp_q.delete(); act_q.delete(); grant_q.delete();
        end else begin
            want = exp_ptr;
            for (int i = 0; i < 4; i++) begin
                e = exp_q.pop_front(); g = act_q.pop_front(); gid = grant_q.pop_front();
                n_checks++;
                if (gid !== want || g !== e) begin n_fail++; $display("FAIL b2b_txn%0d got id=%b rsp=%h want id=%b rsp=%h", i, gid, g, want, e); end
                want = ~want;
            end
            exp_ptr = want;
        end
        exp_cnt = exp_cnt + 16'd4;
        n_checks++; if (op_count !== exp_cnt) begin n_fail++; $display("FAIL b2b_op_count got %0d want %0d", op_count, exp_cnt); end
    endtask

    task automatic test_backpressure();
        rsp_t e, g, snap;
        bit ok;
        logic gid;
        @(posedge clk); #1;
        set_req(0, 32'd9, 32'd4, 4'd5);
        set_req(1, 32'd9, 32'd4, 4'd7);
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_rsp_timeout got no rsp_valid want rsp_valid"); end
        snap = {rsp_id, rsp_out, rsp_flag, rsp_err};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b1 || {rsp_id, rsp_out, rsp_flag, rsp_err} !== snap || req_ready !== 2'b00) begin
                n_fail++; $display("FAIL bp_hold%0d got v=%b rsp=%h ready=%b want 1/%h/00", i, rsp_valid, {rsp_id, rsp_out, rsp_flag, rsp_err}, req_ready, snap);
            end
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_handshake_cycle got ready=%b want 00", req_ready); end
        @(negedge clk);
        n_checks++; if (req_ready !== (exp_ptr ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL bp_next_grant got ready=%b want %b", req_ready, exp_ptr ? 2'b01 : 2'b10); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_rsp(ok);
        n_checks++;
        if (!ok || act_q.size() != 2 || exp_q.size() != 2 || grant_q.size() != 2) begin
            n_fail++; $display("FAIL bp_queue got ok=%0d rsp=%0d want 2", ok, act_q.size());
            exp_q.delete(); act_q.delete(); grant_q.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                e = exp_q.pop_front(); g = act_q.pop_front(); gid = grant_q.pop_front();
                n_checks++;
                if (gid !== exp_ptr || g !== e || (i == 0 && g !== snap)) begin n_fail++; $display("FAIL bp_txn%0d got id=%b rsp=%h want id=%b rsp=%h", i, gid, g, exp_ptr, e); end
                exp_ptr = ~exp_ptr;
            end
        end
        exp_cnt = exp_cnt + 16'd2;
        n_checks++; if (op_count !== exp_cnt) begin n_fail++; $display("FAIL bp_op_count got %0d want %0d", op_count, exp_cnt); end
    endtask

    task automatic test_illegal();
        rsp_t g;
        bit ok;
        run_txn(1, 32'h1234, 32'h5678, 4'b1100, ok);
        n_checks++;
        if (!ok || act_q.size() != 1) begin
            n_fail++; $display("FAIL illegal_timeout got ok=%0d rsp=%0d want 1", ok, act_q.size());
            act_q.delete();
        end else begin
            g = act_q.pop_front();
            if (g !== {1'b1, 32'd0, 1'b0, 1'b1}) begin n_fail++; $display("FAIL illegal_rsp got %h want id=1 out=0 flag=0 err=1", g); end
        end
        exp_q.delete(); grant_q.delete();
        n_checks++; if (op_count !== exp_cnt) begin n_fail++; $display("FAIL illegal_op_count got %0d want %0d", op_count, exp_cnt); end
    endtask

    task automatic test_reset_resp();
        rsp_t e, g;
        bit ok;
        logic gid;
        run_txn(0, 32'd1, 32'd1, 4'd0, ok);
        exp_q.delete(); act_q.delete(); grant_q.delete();
        @(posedge clk); #1;
        set_req(0, 32'd20, 32'd22, 4'd0);
        set_req(1, 32'd30, 32'd33, 4'd0);
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok || grant_q.size() != 1 || grant_q[0] !== 1'b1) begin
            n_fail++; $display("FAIL rr_pre_grant got ok=%0d grants=%0d want one grant to 1", ok, grant_q.size());
        end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (rsp_valid !== 1'b0 || op_count !== 16'd0 || req_ready !== 2'b00) begin n_fail++; $display("FAIL rr_async got v=%b cnt=%0d ready=%b want 0/0/00", rsp_valid, op_count, req_ready); end
        exp_q.delete(); act_q.delete(); grant_q.delete();
        exp_cnt = 16'd0;
        exp_ptr = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rr_first_grant got %b want 01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_rsp(ok);
        n_checks++;
        if (!ok || act_q.size() != 1 || exp_q.size() != 1 || grant_q.size() != 1) begin
            n_fail++; $display("FAIL rr_after got ok=%0d rsp=%0d want 1", ok, act_q.size());
            exp_q.delete(); act_q.delete(); grant_q.delete();
        end else begin
            e = exp_q.pop_front(); g = act_q.pop_front(); gid = grant_q.pop_front();
            if (gid !== 1'b0 || g !== e) begin n_fail++; $display("FAIL rr_after_rsp got id=%b rsp=%h want 0/%h", gid, g, e); end
        end
        exp_cnt = 16'd1;
        exp_ptr = 1'b1;
        n_checks++; if (op_count !== 16'd1) begin n_fail++; $display("FAIL rr_op_count got %0d want 1", op_count); end
    endtask

    task automatic test_saturation();
        bit ok;
        @(negedge clk);
        force dut.op_cnt_q = 16'hFFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.op_cnt_q;
        #1;
        n_checks++; if (op_count !== 16'hFFFE) begin n_fail++; $display("FAIL sat_preload got %h want fffe", op_count); end
        run_txn(0, 32'd2, 32'd2, 4'd0, ok);
        n_checks++; if (!ok || op_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach got ok=%0d cnt=%h want ffff", ok, op_count); end
        run_txn(1, 32'd2, 32'd2, 4'd4, ok);
        n_checks++; if (!ok || op_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got ok=%0d cnt=%h want ffff", ok, op_count); end
        exp_q.delete(); act_q.delete(); grant_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_ops();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_reset_resp();
        test_saturation();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
